// File: rtl/muldiv_multi.sv
// Iterative multiply/divide unit with private HI/LO registers.
// Retires UNROLL bits per CALC cycle, then applies sign correction in SIGN.
module muldiv_multi #(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iStart,
    input  logic [2:0]       iOp,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iFlush,
    output logic             oBusy,
    output logic             oDone,
    output logic             oDivZero,
    output logic [WIDTH-1:0] oHI,
    output logic [WIDTH-1:0] oLO
);

    localparam int N  = WIDTH / UNROLL;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);
    localparam logic [CW-1:0] ZERO_CNT = CW'(0);
    localparam logic [WIDTH-1:0]   ZERO_W  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONES_W  = {WIDTH{1'b1}};
    localparam logic [2*WIDTH-1:0] ZERO_2W = {(2*WIDTH){1'b0}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_SIGN = 2'd2;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ZERO_W - v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ZERO_2W - v;
    endfunction

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? neg_w(v) : v;
    endfunction

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_raw_a;
    logic               r_is_div;
    logic               r_neg_lo;
    logic               r_neg_hi;
    logic               r_bzero;
    logic               r_busy;
    logic               r_done;
    logic               r_divzero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_signed;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    // MULT and DIV are the even opcodes; odd ones are the unsigned forms
    assign w_signed = ~iOp[0];
    assign w_mag_a  = mag(iA, w_signed);
    assign w_mag_b  = mag(iB, w_signed);

    // Accumulator holds {upper, lower}: product/multiplier or remainder/quotient
    always_comb begin
        w_acc_next = r_acc;
        w_trial    = {(WIDTH+1){1'b0}};
        w_sum      = {(WIDTH+1){1'b0}};
        for (int k = 0; k < UNROLL; k++) begin
            if (r_is_div) begin
                w_trial = w_acc_next[2*WIDTH-1:WIDTH-1] - {1'b0, r_b};
                if (!w_trial[WIDTH]) begin
                    w_acc_next = {w_trial[WIDTH-1:0], w_acc_next[WIDTH-2:0], 1'b1};
                end else begin
                    w_acc_next = {w_acc_next[2*WIDTH-2:0], 1'b0};
                end
            end else begin
                w_sum = {1'b0, w_acc_next[2*WIDTH-1:WIDTH]}
                      + (w_acc_next[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
                w_acc_next = {w_sum, w_acc_next[WIDTH-1:1]};
            end
        end
    end

    // Sign correction and divide-by-zero override applied in SIGN
    always_comb begin
        w_prod = r_neg_lo ? neg_2w(r_acc) : r_acc;
        if (!r_is_div) begin
            w_res_hi = w_prod[2*WIDTH-1:WIDTH];
            w_res_lo = w_prod[WIDTH-1:0];
        end else if (r_bzero) begin
            w_res_hi = r_raw_a;
            w_res_lo = ONES_W;
        end else begin
            w_res_hi = r_neg_hi ? neg_w(r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];
            w_res_lo = r_neg_lo ? neg_w(r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
        end
    end

    // Control FSM, datapath registers and HI/LO
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_state   <= S_IDLE;
            r_cnt     <= ZERO_CNT;
            r_acc     <= ZERO_2W;
            r_b       <= ZERO_W;
            r_raw_a   <= ZERO_W;
            r_is_div  <= 1'b0;
            r_neg_lo  <= 1'b0;
            r_neg_hi  <= 1'b0;
            r_bzero   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
            r_hi      <= ZERO_W;
            r_lo      <= ZERO_W;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (iStart && !iFlush) begin
                        case (iOp)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                r_is_div  <= iOp[1];
                                r_acc     <= iOp[1] ? {ZERO_W, w_mag_a} : {ZERO_W, w_mag_b};
                                r_b       <= iOp[1] ? w_mag_b : w_mag_a;
                                r_raw_a   <= iA;
                                r_bzero   <= (iB == ZERO_W);
                                r_neg_lo  <= w_signed & (iA[WIDTH-1] ^ iB[WIDTH-1]);
                                r_neg_hi  <= w_signed & iOp[1] & iA[WIDTH-1];
                                r_cnt     <= ZERO_CNT;
                                r_divzero <= 1'b0;
                                r_busy    <= 1'b1;
                                r_state   <= S_CALC;
                            end
                            3'd4:    r_hi <= iA;
                            3'd5:    r_lo <= iA;
                            default: ;
                        endcase
                    end
                end
                S_CALC: begin
                    if (iFlush) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + ONE_CNT;
                        if (r_cnt == LAST_CNT) begin
                            r_state <= S_SIGN;
                        end
                    end
                end
                S_SIGN: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                    if (!iFlush) begin
                        r_hi      <= w_res_hi;
                        r_lo      <= w_res_lo;
                        r_done    <= 1'b1;
                        r_divzero <= r_is_div & r_bzero;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign oBusy    = r_busy;
    assign oDone    = r_done;
    assign oDivZero = r_divzero;
    assign oHI      = r_hi;
    assign oLO      = r_lo;

endmodule
